// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: PARK/OWN/LOCK FSM, tenure limit, registered HGRANT/HMASTER/HMASTLOCK.
// Define ARB_ROUND_ROBIN_EN to use round-robin winner search instead of fixed lowest-index priority.
module ahb_arbiter #(
    parameter int unsigned NUM_MASTERS    = 3,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_BEATS      = 16
) (
    input  logic                   clock,
    input  logic                   nRst,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic                   HREADY,
    input  logic [1:0]             HTRANS,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [1:0]             HMASTER,
    output logic                   HMASTLOCK
);
    typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;

    localparam logic [1:0]             DEF_IDX   = 2'(DEFAULT_MASTER);
    localparam logic [7:0]             MAX_T     = 8'(MAX_BEATS);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    state_t                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [7:0]             tenure_q, tenure_d;
    logic [1:0]             hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0]             ptr_q, ptr_d;
`endif

    logic [3:0] req, lck, owner_oh;
    logic [1:0] win_idx, cand;
    logic       win_found, rearb;
    logic       unused_htrans0;

    // Requests widened to 4 bits so a 2-bit index is always in range.
    assign req            = 4'(HBUSREQ);
    assign lck            = 4'(HLOCK);
    assign owner_oh       = 4'b0001 << idx_q;
    assign unused_htrans0 = HTRANS[0];

    always_comb begin
        win_idx   = DEF_IDX;
        win_found = 1'b0;
        cand      = '0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = 2'((32'(ptr_q) + k) % NUM_MASTERS);
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
`else
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = 2'(i);
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tenure_d    = tenure_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        rearb       = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        if (HREADY) begin
            hmaster_d   = idx_q;
            hmastlock_d = lck[idx_q];
            if (state_q == LOCK) begin
                if (!req[idx_q])
                    rearb = 1'b1;
                else if (!lck[idx_q])
                    state_d = OWN;
            end else begin
                rearb = !req[idx_q]
                      || (tenure_q == MAX_T && |(req & ~owner_oh))
                      || (state_q == PARK && |req);
                if (!rearb && state_q == OWN && lck[idx_q])
                    state_d = LOCK;
            end
            if (rearb) begin
                if (win_found) begin
                    idx_d   = win_idx;
                    state_d = OWN;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = win_idx;
`endif
                end else begin
                    idx_d   = DEF_IDX;
                    state_d = PARK;
                end
            end
            if (idx_d != idx_q)
                tenure_d = '0;
            else if (HTRANS[1] && tenure_q < MAX_T)
                tenure_d = tenure_q + 8'd1;
        end
    end

    always_comb begin
        grant_d = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++)
            grant_d[i] = (idx_d == 2'(i));
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state_q     <= PARK;
            idx_q       <= DEF_IDX;
            grant_q     <= DEF_GRANT;
            tenure_q    <= '0;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= DEF_IDX;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            grant_q     <= grant_d;
            tenure_q    <= tenure_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: behavioural model pushes expected outputs per edge, monitor pops and compares.
module tb_ahb_arbiter;
    localparam int NM   = 3;
    localparam int DEF  = 0;
    localparam int MAXB = 16;

    logic          clock = 1'b0;
    logic          nRst;
    logic [NM-1:0] HBUSREQ, HLOCK;
    logic          HREADY;
    logic [1:0]    HTRANS;
    logic [NM-1:0] HGRANT;
    logic [1:0]    HMASTER;
    logic          HMASTLOCK;
    bit            probe_req = 1'b0;

    always #5 clock = ~clock;

    ahb_arbiter #(.NUM_MASTERS(NM), .DEFAULT_MASTER(DEF), .MAX_BEATS(MAXB)) dut (
        .clock(clock), .nRst(nRst), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HREADY(HREADY), .HTRANS(HTRANS), .HGRANT(HGRANT),
        .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
    );

    typedef struct {
        logic [NM-1:0] grant;
        logic [1:0]    master;
        logic          mlock;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: who owns the bus, whether parked/locked, beats used so far.
    int m_owner, m_tenure, m_ptr, m_hmaster;
    bit m_parked, m_locked, m_mlock;

    function automatic int pick_winner(input logic [NM-1:0] r, input int ptr);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NM; k++)
            if (r[(ptr + k) % NM]) return (ptr + k) % NM;
`else
        for (int c = 0; c < NM; c++)
            if (r[c]) return c;
`endif
        return DEF;
    endfunction

    always @(posedge clock or negedge nRst) begin
        exp_t e;
        if (!nRst) begin
            m_owner = DEF; m_tenure = 0; m_ptr = DEF; m_hmaster = DEF;
            m_parked = 1'b1; m_locked = 1'b0; m_mlock = 1'b0;
            sb.delete();
        end else if (HREADY) begin
            int  nxt;
            bit  go;
            bit  others;
            m_hmaster = m_owner;
            m_mlock   = HLOCK[m_owner];
            others    = (HBUSREQ & ~(NM'(1) << m_owner)) != '0;
            nxt       = m_owner;
            go        = 1'b0;
            if (m_locked) begin
                if (!HBUSREQ[m_owner]) go = 1'b1;
                else if (!HLOCK[m_owner]) m_locked = 1'b0;
            end else begin
                go = !HBUSREQ[m_owner] || (m_tenure >= MAXB && others)
                     || (m_parked && HBUSREQ != '0);
                if (!go && !m_parked && HLOCK[m_owner]) m_locked = 1'b1;
            end
            if (go) begin
                m_locked = 1'b0;
                if (HBUSREQ == '0) begin
                    nxt = DEF;
                    m_parked = 1'b1;
                end else begin
                    nxt = pick_winner(HBUSREQ, m_ptr);
                    m_parked = 1'b0;
                    m_ptr = nxt;
                end
            end
            if (nxt != m_owner) m_tenure = 0;
            else if (HTRANS[1] && m_tenure < MAXB) m_tenure++;
            m_owner = nxt;
        end
        e.grant  = NM'(1) << m_owner;
        e.master = 2'(m_hmaster);
        e.mlock  = m_mlock;
        sb.push_back(e);
    end

    // Monitor: pops one expectation per falling clock edge; also probes async reset on request.
    initial forever begin
        @(negedge clock or posedge probe_req);
        if (probe_req) begin
            n_cmp++;
            if (HGRANT !== NM'(1 << DEF) || HMASTER !== 2'(DEF) || HMASTLOCK !== 1'b0) begin
                n_bad++;
                $display("FAIL async_reset: got grant=%b master=%0d mlock=%b, want grant=%b master=%0d mlock=0",
                         HGRANT, HMASTER, HMASTLOCK, NM'(1 << DEF), DEF);
            end
        end else if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (HGRANT !== e.grant || HMASTER !== e.master || HMASTLOCK !== e.mlock) begin
                n_bad++;
                $display("FAIL outputs @%0t: got grant=%b master=%0d mlock=%b, want grant=%b master=%0d mlock=%b",
                         $time, HGRANT, HMASTER, HMASTLOCK, e.grant, e.master, e.mlock);
            end
            n_cmp++;
            if (!$onehot(HGRANT)) begin
                n_bad++;
                $display("FAIL onehot @%0t: got grant=%b, want exactly one bit set", $time, HGRANT);
            end
        end
    end

    task automatic cyc(input logic [NM-1:0] r, input logic [NM-1:0] l,
                       input logic rdy, input logic [1:0] t, input int n);
        HBUSREQ = r; HLOCK = l; HREADY = rdy; HTRANS = t;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [NM-1:0] r, l;
        nRst = 1'b0; HBUSREQ = '0; HLOCK = '0; HREADY = 1'b1; HTRANS = 2'b00;
        repeat (3) @(negedge clock);
        nRst = 1'b1;
        cyc(3'b000, 3'b000, 1'b1, 2'b00, 3);
        cyc(3'b110, 3'b000, 1'b1, 2'b10, 3);
        cyc(3'b111, 3'b000, 1'b1, 2'b10, 22);
        cyc(3'b000, 3'b000, 1'b1, 2'b00, 2);
        cyc(3'b100, 3'b100, 1'b1, 2'b10, 3);
        cyc(3'b101, 3'b100, 1'b1, 2'b11, 40);
        cyc(3'b101, 3'b000, 1'b1, 2'b11, 5);
        cyc(3'b001, 3'b000, 1'b1, 2'b10, 3);
        cyc(3'b010, 3'b000, 1'b1, 2'b10, 3);
        cyc(3'b001, 3'b000, 1'b0, 2'b10, 3);
        cyc(3'b001, 3'b000, 1'b1, 2'b10, 2);
        cyc(3'b100, 3'b100, 1'b1, 2'b10, 4);
        @(posedge clock);
        #2 nRst = 1'b0;
        #1 probe_req = 1'b1;
        #1 probe_req = 1'b0;
        @(negedge clock);
        cyc(3'b100, 3'b100, 1'b1, 2'b10, 2);
        nRst = 1'b1;
        cyc(3'b000, 3'b000, 1'b1, 2'b00, 2);
        r = '0; l = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) r = NM'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) l = r & NM'($urandom_range(0, 7));
            cyc(r, l, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1);
        end
        cyc(3'b000, 3'b000, 1'b1, 2'b00, 3);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3, number of bus masters; legal range 2..4.
REQ-002 Parameter DEFAULT_MASTER, default 0, master parked on the bus when no requests are pending.
REQ-003 Parameter MAX_BEATS, default 16, maximum tenure beats before forced re-arbitration; legal range 1..255.
REQ-004 clock  input  1  system clock; all state updates on the rising edge.
REQ-005 nRst  input  1  reset, asynchronous, active-low.
REQ-006 HBUSREQ  input  NUM_MASTERS  bus request, one bit per master.
REQ-007 HLOCK  input  NUM_MASTERS  locked-transfer request, one bit per master.
REQ-008 HREADY  input  1  slave ready; ends the current data phase.
REQ-009 HTRANS  input  2  transfer type of the current address phase; bit 1 set means NONSEQ or SEQ.
REQ-010 HGRANT  output  NUM_MASTERS  one-hot bus grant, registered.
REQ-011 HMASTER  output  2  index of the master owning the address phase, registered.
REQ-012 HMASTLOCK  output  1  current address phase is locked, registered.

Function
REQ-013 The FSM SHALL have three states: PARK (DEFAULT_MASTER granted, no request pending), OWN (requester granted, unlocked), LOCK (owner holds HLOCK and HBUSREQ).
REQ-014 HGRANT, the FSM and the tenure counter SHALL update only on edges where HREADY=1; with HREADY=0 all three hold.
REQ-015 Re-arbitration SHALL occur when HREADY=1 and the state is not LOCK and any of the following holds: owner HBUSREQ=0; tenure=MAX_BEATS with another request pending; state is PARK with any request pending.
REQ-016 Winner selection SHALL use fixed priority, lowest index wins, unless ARB_ROUND_ROBIN_EN is defined (REQ-027).
REQ-017 No pending request SHALL yield HGRANT one-hot at DEFAULT_MASTER and state PARK.
REQ-018 The OWN to LOCK transition SHALL occur on the HREADY=1 edge where the owner has HLOCK=1 and HBUSREQ=1.
REQ-019 The LOCK to OWN transition SHALL occur on the HREADY=1 edge where the owner has HLOCK=0. LOCK SHALL exit to re-arbitration when the owner's HBUSREQ=0.
REQ-020 In LOCK, the tenure limit SHALL be ignored and no other master SHALL be granted.
REQ-021 Tenure counter: 8 bits; increments on edges with HREADY=1 and HTRANS[1]=1; clears to 0 on every grant change; saturates at MAX_BEATS.
REQ-022 HMASTER SHALL load the index of the currently granted master on each edge with HREADY=1, lagging HGRANT by one HREADY cycle.
REQ-023 HMASTLOCK SHALL load HLOCK[granted index] on the same edge as REQ-022.
REQ-024 HGRANT SHALL be exactly one-hot in every cycle; a simultaneous drop of the owner request and a rise of another request SHALL re-arbitrate in that same HREADY=1 edge.
REQ-025 Requests from indices at or above NUM_MASTERS SHALL not exist; the HMASTER upper bit SHALL be 0 when NUM_MASTERS is 2.

Reset
REQ-026 While nRst=0, regardless of clock or any transfer in progress:
- HGRANT SHALL be one-hot at DEFAULT_MASTER.
- HMASTER SHALL be DEFAULT_MASTER.
- HMASTLOCK SHALL be 0.
- State SHALL be PARK.
- Tenure SHALL be 0.
- The round-robin pointer SHALL be DEFAULT_MASTER.

Configuration
REQ-027 With macro ARB_ROUND_ROBIN_EN defined, the search SHALL start at (last granted index + 1) mod NUM_MASTERS and wrap around. The pointer SHALL update on every grant to a requester; parking SHALL not update it.
REQ-028 Without ARB_ROUND_ROBIN_EN, fixed lowest-index priority SHALL apply and no pointer register SHALL exist.

Verification
REQ-029 Reset release with HBUSREQ=000 -> HGRANT=001, HMASTER=0, HMASTLOCK=0, state PARK.
REQ-030 HBUSREQ=110, HREADY=1 -> next edge HGRANT=010; the following edge HMASTER=1.
REQ-031 Master 1 owns the bus, HBUSREQ=111, HTRANS=NONSEQ, 16 HREADY beats -> after the 16th beat, HGRANT=001 under fixed priority and HGRANT=100 with ARB_ROUND_ROBIN_EN.
REQ-032 Master 2 has HLOCK=1 and HBUSREQ=1, master 0 requests for 40 beats -> HGRANT stays 100 and HMASTLOCK=1 throughout; master 2 drops HLOCK -> HMASTLOCK=0, and master 0 is granted once tenure reaches MAX_BEATS or master 2 releases.
REQ-033 Grant change pending with HREADY held 0 for 3 cycles -> HGRANT and HMASTER unchanged until the HREADY=1 edge.
REQ-034 nRst asserted mid-LOCK with HGRANT=100 -> immediately HGRANT=001, HMASTLOCK=0, HMASTER=0.
